// File: rtl/sdhci_cmd_pkg.sv
// Shared types and constants for the SD command-line engine and its CRC7 helper.
package sdhci_cmd_pkg;

  typedef enum logic [1:0] {
    RSP_NONE    = 2'b00,
    RSP_136     = 2'b01,
    RSP_48      = 2'b10,
    RSP_48_BUSY = 2'b11
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_RSP,
    ST_RX,
    ST_DONE
  } cmd_state_e;

  localparam logic [6:0] CRC7_POLY     = 7'h09;  // x^7 + x^3 + 1
  localparam int         TOKEN_LEN     = 48;
  localparam int         TOKEN_CRC_LEN = 40;
  localparam int         RSP_SHORT_LEN = 48;
  localparam int         RSP_LONG_LEN  = 136;

  // Index of the last received bit (start bit is bit 0).
  function automatic logic [7:0] rsp_last_bit(resp_type_e t);
    return (t == RSP_136) ? 8'(RSP_LONG_LEN - 1) : 8'(RSP_SHORT_LEN - 1);
  endfunction

endpackage

// File: rtl/sdhci_crc7.sv
// Serial CRC7 (x^7+x^3+1): synchronous clear, one bit per enabled cycle.
module sdhci_crc7
  import sdhci_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_o <= '0;
    end else if (clr_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[5:0], 1'b0} ^ ({7{bit_i ^ crc_o[6]}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sdhci_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command token and captures/checks the reply.
// Define SDHCI_CMD_RSP_CRC_EN to build the receive CRC7 checker.
module sdhci_cmd_engine
  import sdhci_cmd_pkg::*;
#(
  parameter int ResponseTimeout = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sd_clk_en_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  input  logic         check_index_i,
  input  logic         check_crc_i,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  output logic         busy_o,
  output logic         complete_o,
  output logic [119:0] response_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  localparam logic [7:0] TimeoutCnt = 8'(ResponseTimeout);

  cmd_state_e   state_reg;
  resp_type_e   resp_type_reg;
  logic [5:0]   index_reg;
  logic         check_index_reg;
  logic [39:0]  tx_shift_reg;
  logic [7:0]   bit_cnt_reg;
  logic [7:0]   wait_cnt_reg;
  logic [134:0] rx_shift_reg;

  logic [6:0]   tx_crc;
  logic         accept;
  logic         tx_crc_en;
  logic         tx_bit;
  logic [135:0] rx_next;
  logic         is_long;
  logic         rx_last;
  logic         index_bad;
  logic         end_bad;
  logic         crc_bad;
  logic [7:0]   wait_cnt_next;

  assign accept        = (state_reg == ST_IDLE) && start_i;
  assign tx_crc_en     = (state_reg == ST_TX) && sd_clk_en_i && (bit_cnt_reg < 8'(TOKEN_CRC_LEN));
  assign rx_next       = {rx_shift_reg, cmd_i};
  assign is_long       = (resp_type_reg == RSP_136);
  assign rx_last       = (bit_cnt_reg == rsp_last_bit(resp_type_reg));
  assign index_bad     = check_index_reg && !is_long && (rx_next[45:40] != index_reg);
  assign end_bad       = !rx_next[0];
  assign wait_cnt_next = wait_cnt_reg + 8'd1;

  // Token bit: header+arg from the shifter, then the CRC7 MSB first, then the end bit.
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt_reg < 8'(TOKEN_CRC_LEN)) begin
      tx_bit = tx_shift_reg[39];
    end else if (bit_cnt_reg < 8'(TOKEN_LEN - 1)) begin
      tx_bit = tx_crc[3'(8'd46 - bit_cnt_reg)];
    end
  end

  sdhci_crc7 u_tx_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .en_i  (tx_crc_en),
    .bit_i (tx_shift_reg[39]),
    .crc_o (tx_crc)
  );

`ifdef SDHCI_CMD_RSP_CRC_EN
  logic       check_crc_reg;
  logic       rx_crc_en;
  logic [6:0] rx_crc;
  logic [7:0] unused_rx_bits;

  // Short replies cover the start bit onward; R2 skips the 8-bit header.
  assign rx_crc_en = sd_clk_en_i &&
                     (((state_reg == ST_WAIT_RSP) && !cmd_i && !is_long) ||
                      ((state_reg == ST_RX) &&
                       (is_long ? (bit_cnt_reg >= 8'd8 && bit_cnt_reg < 8'd128)
                                : (bit_cnt_reg < 8'(TOKEN_CRC_LEN)))));
  assign crc_bad        = check_crc_reg && (rx_crc != rx_next[7:1]);
  assign unused_rx_bits = rx_next[135:128];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      check_crc_reg <= 1'b0;
    end else if (accept) begin
      check_crc_reg <= check_crc_i;
    end
  end

  sdhci_crc7 u_rx_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .en_i  (rx_crc_en),
    .bit_i (cmd_i),
    .crc_o (rx_crc)
  );
`else
  logic [15:0] unused_rx_bits;

  assign crc_bad        = 1'b0;
  assign unused_rx_bits = {rx_next[135:128], rx_next[7:1], check_crc_i};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      resp_type_reg   <= RSP_NONE;
      index_reg       <= '0;
      check_index_reg <= 1'b0;
      tx_shift_reg    <= '0;
      bit_cnt_reg     <= '0;
      wait_cnt_reg    <= '0;
      rx_shift_reg    <= '0;
      cmd_o           <= 1'b1;
      cmd_oe_o        <= 1'b0;
      busy_o          <= 1'b0;
      complete_o      <= 1'b0;
      response_o      <= '0;
      timeout_err_o   <= 1'b0;
      crc_err_o       <= 1'b0;
      end_bit_err_o   <= 1'b0;
      index_err_o     <= 1'b0;
    end else begin
      complete_o    <= 1'b0;
      timeout_err_o <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      index_err_o   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cmd_o    <= 1'b1;
          cmd_oe_o <= 1'b0;
          if (start_i) begin
            index_reg       <= cmd_index_i;
            tx_shift_reg    <= {2'b01, cmd_index_i, cmd_arg_i};
            resp_type_reg   <= resp_type_e'(resp_type_i);
            check_index_reg <= check_index_i;
            bit_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            busy_o          <= 1'b1;
            state_reg       <= ST_TX;
          end
        end
        ST_TX: begin
          if (sd_clk_en_i) begin
            cmd_o    <= tx_bit;
            cmd_oe_o <= 1'b1;
            if (bit_cnt_reg < 8'(TOKEN_CRC_LEN)) begin
              tx_shift_reg <= {tx_shift_reg[38:0], 1'b0};
            end
            if (bit_cnt_reg == 8'(TOKEN_LEN - 1)) begin
              bit_cnt_reg  <= '0;
              wait_cnt_reg <= '0;
              if (resp_type_reg == RSP_NONE) begin
                complete_o <= 1'b1;
                busy_o     <= 1'b0;
                state_reg  <= ST_DONE;
              end else begin
                state_reg <= ST_WAIT_RSP;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 8'd1;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (sd_clk_en_i) begin
            cmd_o        <= 1'b1;
            cmd_oe_o     <= 1'b0;
            rx_shift_reg <= rx_next[134:0];
            if (!cmd_i) begin
              bit_cnt_reg <= 8'd1;
              state_reg   <= ST_RX;
            end else begin
              wait_cnt_reg <= wait_cnt_next;
              if (wait_cnt_next == TimeoutCnt) begin
                timeout_err_o <= 1'b1;
                complete_o    <= 1'b1;
                busy_o        <= 1'b0;
                state_reg     <= ST_DONE;
              end
            end
          end
        end
        ST_RX: begin
          if (sd_clk_en_i) begin
            rx_shift_reg <= rx_next[134:0];
            if (rx_last) begin
              complete_o    <= 1'b1;
              busy_o        <= 1'b0;
              end_bit_err_o <= end_bad;
              index_err_o   <= index_bad;
              crc_err_o     <= crc_bad;
              response_o    <= is_long ? rx_next[127:8] : {88'b0, rx_next[39:8]};
              state_reg     <= ST_DONE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 8'd1;
            end
          end
        end
        ST_DONE: begin
          cmd_o     <= 1'b1;
          cmd_oe_o  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_engine.sv
// Directed bench for sdhci_cmd_engine: token shapes, reply checks, timeout and reset.
module tb_sdhci_cmd_engine;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         sd_clk_en_i = 1'b0;
  logic         start_i;
  logic [5:0]   cmd_index_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   resp_type_i;
  logic         check_index_i;
  logic         check_crc_i;
  logic         cmd_i;
  logic         cmd_o;
  logic         cmd_oe_o;
  logic         busy_o;
  logic         complete_o;
  logic [119:0] response_o;
  logic         timeout_err_o;
  logic         crc_err_o;
  logic         end_bit_err_o;
  logic         index_err_o;

  int checks   = 0;
  int failures = 0;
  logic [1:0] tick_div = 2'd0;

`ifdef SDHCI_CMD_RSP_CRC_EN
  localparam logic CrcErrExp = 1'b1;
`else
  localparam logic CrcErrExp = 1'b0;
`endif

  sdhci_cmd_engine #(.ResponseTimeout(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .sd_clk_en_i   (sd_clk_en_i),
    .start_i       (start_i),
    .cmd_index_i   (cmd_index_i),
    .cmd_arg_i     (cmd_arg_i),
    .resp_type_i   (resp_type_i),
    .check_index_i (check_index_i),
    .check_crc_i   (check_crc_i),
    .cmd_i         (cmd_i),
    .cmd_o         (cmd_o),
    .cmd_oe_o      (cmd_oe_o),
    .busy_o        (busy_o),
    .complete_o    (complete_o),
    .response_o    (response_o),
    .timeout_err_o (timeout_err_o),
    .crc_err_o     (crc_err_o),
    .end_bit_err_o (end_bit_err_o),
    .index_err_o   (index_err_o)
  );

  always #5 clk = ~clk;

  // SD bit tick once every four system clocks, changed away from the active edge.
  always @(negedge clk) begin
    tick_div    = tick_div + 2'd1;
    sd_clk_en_i = (tick_div == 2'd0);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (sd_clk_en_i !== 1'b1);
    #1;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic ci, input logic cc);
    @(negedge clk);
    cmd_index_i   = idx;
    cmd_arg_i     = arg;
    resp_type_i   = rt;
    check_index_i = ci;
    check_crc_i   = cc;
    start_i       = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Collects the 48 token bits; optionally pokes a second start mid-token.
  task automatic capture_token(output logic [47:0] tok, output logic oe_ok, input int poke_at);
    tok   = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      wait_tick();
      tok = {tok[46:0], cmd_o};
      if (cmd_oe_o !== 1'b1) oe_ok = 1'b0;
      if (i == poke_at) begin
        cmd_index_i = 6'h3F;
        cmd_arg_i   = 32'hFFFF_FFFF;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
    end
  endtask

  task automatic send_response(input logic [135:0] frame, input int len, input int gap);
    for (int g = 0; g < gap; g++) begin
      cmd_i = 1'b1;
      wait_tick();
    end
    for (int i = len - 1; i >= 0; i--) begin
      cmd_i = frame[i];
      wait_tick();
    end
  endtask

  task automatic check_done(input string tag, input logic to, input logic crc,
                            input logic eb, input logic ie);
    check({tag, ".complete"}, complete_o, 1'b1);
    check({tag, ".busy"}, busy_o, 1'b0);
    check({tag, ".errs"}, {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o},
          {to, crc, eb, ie});
    $display("txn %s: complete=%0b busy=%0b to=%0b crc=%0b eb=%0b idx=%0b resp=%0h",
             tag, complete_o, busy_o, timeout_err_o, crc_err_o, end_bit_err_o,
             index_err_o, response_o);
    cmd_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [47:0]  tok;
  logic         oe_ok;
  logic [135:0] frame;
  logic         saw_complete;

  initial begin
    rst_i         = 1'b1;
    start_i       = 1'b0;
    cmd_index_i   = '0;
    cmd_arg_i     = '0;
    resp_type_i   = 2'b00;
    check_index_i = 1'b0;
    check_crc_i   = 1'b0;
    cmd_i         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs", {cmd_o, cmd_oe_o, busy_o, complete_o}, 4'b1000);
    check("reset.response", response_o, 120'h0);
    @(negedge clk);
    rst_i = 1'b0;

    // CMD0, no response
    issue(6'd0, 32'h0, 2'b00, 1'b0, 1'b0);
    check("cmd0.busy_rise", busy_o, 1'b1);
    capture_token(tok, oe_ok, -1);
    check("cmd0.token", tok, 48'h40_0000_0000_95);
    check("cmd0.oe", oe_ok, 1'b1);
    check_done("cmd0", 1'b0, 1'b0, 1'b0, 1'b0);
    check("cmd0.complete_fall", complete_o, 1'b0);

    // CMD8 with a good R7 reply
    issue(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b1);
    capture_token(tok, oe_ok, -1);
    check("cmd8.token", tok, 48'h48_0000_01AA_87);
    frame = 136'h08_0000_01AA_13;
    send_response(frame, 48, 2);
    check("cmd8.response", response_o, 120'h1AA);
    check("cmd8.oe_off", cmd_oe_o, 1'b0);
    check_done("cmd8", 1'b0, 1'b0, 1'b0, 1'b0);

    // CMD8 with a corrupted reply CRC field
    issue(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b1);
    capture_token(tok, oe_ok, -1);
    frame = 136'h08_0000_01AA_15;
    send_response(frame, 48, 0);
    check_done("cmd8_badcrc", 1'b0, CrcErrExp, 1'b0, 1'b0);

    // Reply index 9 to CMD8
    issue(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b0);
    capture_token(tok, oe_ok, -1);
    frame = 136'h09_0000_01AA_13;
    send_response(frame, 48, 1);
    check_done("cmd8_idx", 1'b0, 1'b0, 1'b0, 1'b1);

    // Same, with the end bit low
    issue(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b0);
    capture_token(tok, oe_ok, -1);
    frame = 136'h09_0000_01AA_12;
    send_response(frame, 48, 1);
    check_done("cmd8_idx_end", 1'b0, 1'b0, 1'b1, 1'b1);

    // R2 136-bit reply
    issue(6'd2, 32'h0, 2'b01, 1'b1, 1'b0);
    capture_token(tok, oe_ok, -1);
    frame = {8'h3F, 120'h0123456789ABCDEF_FEDCBA98765432, 8'h01};
    send_response(frame, 136, 3);
    check("r2.response", response_o, 120'h0123456789ABCDEF_FEDCBA98765432);
    check_done("r2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout with CMD held high: fires on the 64th tick after the end bit
    issue(6'd8, 32'h0000_01AA, 2'b11, 1'b1, 1'b1);
    capture_token(tok, oe_ok, -1);
    cmd_i        = 1'b1;
    saw_complete = 1'b0;
    for (int i = 0; i < 63; i++) begin
      wait_tick();
      if (complete_o === 1'b1) saw_complete = 1'b1;
    end
    check("timeout.early", saw_complete, 1'b0);
    wait_tick();
    check("timeout.response_held", response_o, 120'h0123456789ABCDEF_FEDCBA98765432);
    check_done("timeout", 1'b1, 1'b0, 1'b0, 1'b0);

    // start_i during TX is ignored
    issue(6'd0, 32'h0, 2'b00, 1'b0, 1'b0);
    capture_token(tok, oe_ok, 10);
    check("midstart.token", tok, 48'h40_0000_0000_95);
    check_done("midstart", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a token
    issue(6'd8, 32'h0000_01AA, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) wait_tick();
    rst_i = 1'b1;
    #1;
    check("rst_mid.outs", {cmd_o, cmd_oe_o, busy_o}, 3'b100);
    check("rst_mid.response", response_o, 120'h0);
    @(negedge clk);
    rst_i        = 1'b0;
    saw_complete = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (complete_o === 1'b1 || busy_o === 1'b1) saw_complete = 1'b1;
    end
    check("rst_mid.no_complete", saw_complete, 1'b0);
    $display("txn rst_mid: busy=%0b complete_seen=%0b", busy_o, saw_complete);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdhci_cmd_engine.md
# sdhci_cmd_engine

Serial command-line engine of the SDHCI controller. It drives a command token onto the SD CMD line when the register file issues a command, then captures and checks the card's response. It reports completion and per-error pulses back to the register logic. It is the producer of the command-inhibit, command-complete and command-error events that the register block turns into interrupt status bits.

## Interface
Parameters:
- `ResponseTimeout`, default 64: number of SD clock ticks to wait for a response start bit before flagging a timeout (range 2..255).

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `sd_clk_en_i` in 1: one-`clk_i` tick per SD bit period; all CMD-line shifting happens only on tick cycles.
- `start_i` in 1: issue request, single-cycle pulse; sampled only in IDLE.
- `cmd_index_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `resp_type_i` in 2: 00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy (busy is treated as 48-bit here).
- `check_index_i` in 1: enables the response index check.
- `check_crc_i` in 1: enables the response CRC check.
- `cmd_i` in 1: CMD line input from pad.
- `cmd_o` out 1: CMD line output to pad.
- `cmd_oe_o` out 1: CMD pad output enable.
- `busy_o` out 1: command inhibit (CMD).
- `complete_o` out 1: one-cycle command-complete pulse.
- `response_o` out 120: captured response. For R2, bits [127:8] of the card frame. For 48-bit responses, card bits [39:8] in [31:0] and zeros above.
- `timeout_err_o`, `crc_err_o`, `end_bit_err_o`, `index_err_o` out 1 each: error pulses, coincident with `complete_o`.

## Operation
- States: IDLE, TX, WAIT_RSP, RX, DONE.
- IDLE: `cmd_oe_o`=0, `cmd_o`=1. When `start_i`=1, latch index, arg, resp type and check enables, clear the CRC, set `busy_o`, and go to TX. `start_i` in any other state is ignored.
- TX: 48-bit token, MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
  - CRC7 uses polynomial x^7+x^3+1 and is computed serially over the first 40 bits.
  - One bit per tick. `cmd_oe_o`=1 from the first bit until the tick after the end bit.
- After the 48th bit: if resp type is 00, go to DONE. Otherwise go to WAIT_RSP with the tick counter at 0.
- WAIT_RSP: `cmd_oe_o`=0. Each tick:
  - `cmd_i`=0: go to RX (start bit counted as bit 0).
  - Otherwise increment the counter. If it reaches `ResponseTimeout`, set timeout and go to DONE.
- RX: shift `cmd_i` in each tick until 48 or 136 bits total.
  - 48-bit CRC covers bits [47:8].
  - 136-bit CRC covers bits [127:8]; header bits [135:128] are excluded.
- End-of-RX checks:
  - End bit must be 1, else `end_bit_err_o`.
  - Bits [45:40] must equal the index when `check_index_i`=1 and the type is 48-bit, else `index_err_o`.
  - Received CRC field must match when `check_crc_i`=1, else `crc_err_o`.
  - Checks are independent; several errors may pulse together.
- DONE: for one cycle, `complete_o`=1, error pulses are valid, and `busy_o` drops. Next state is IDLE.
- `response_o` updates only on the DONE cycle of a non-timeout response. It holds its value otherwise.
- Reset (any time, including mid-token): state IDLE, `cmd_o`=1, `cmd_oe_o`=0, `busy_o`=0, all pulses 0, `response_o`=0, counters 0.

## Timing
- `busy_o` rises the `clk_i` cycle after `start_i` is sampled.
- `cmd_o` and the receive shift register update on `clk_i` edges where `sd_clk_en_i`=1. The first token bit appears on the first tick after entering TX.
- No-response command: `complete_o` arrives 1 `clk_i` cycle after the 48th-bit tick.
- Timeout fires on tick number `ResponseTimeout` counted after the end bit.
- `busy_o` falls in the same cycle as `complete_o`. A new `start_i` is accepted from the following cycle.

## Configuration
- `SDHCI_CMD_RSP_CRC_EN` defined: response CRC7 checker present, behaving as described above.
- Not defined: no receive CRC logic is built, `crc_err_o` is tied 0, and `check_crc_i` is ignored. Transmit CRC is always present.

## Structure
- Package `sdhci_cmd_pkg`: `resp_type_e`, `cmd_state_e`, CRC7 polynomial constant, token and response length constants.
- Sub-module `sdhci_crc7`: serial CRC7 with clear, enable and bit inputs and a 7-bit output. Instantiate it once for TX and once for RX; the RX instance exists only under the macro.

## Test plan
- CMD0, arg 0x00000000, resp none -> token 0x400000000095 on `cmd_o`, `complete_o` 1 cycle after bit 48, no errors.
- CMD8, arg 0x000001AA, resp 48-bit, card replies 0x08000001AA13 -> `response_o[31:0]`=0x000001AA, no errors.
- Same as the CMD8 case, but the reply CRC field is corrupted and the checks are enabled -> `crc_err_o`=1 with `complete_o`. Without the macro -> no error.
- 48-bit response, `cmd_i` held 1 with `ResponseTimeout`=64 -> `timeout_err_o` and `complete_o` on the 64th tick, `response_o` unchanged.
- Reply index 9 to CMD8 with `check_index_i`=1 -> `index_err_o`=1. Same reply with end bit 0 -> `end_bit_err_o` also set.
- `start_i` pulsed mid-TX -> ignored (token unchanged). `rst_i` mid-TX -> `cmd_oe_o`=0, `busy_o`=0 immediately, no `complete_o`.
